convert_inverse_seq: RTL and testbench

- Sequential decoder for the 8-bit Fahrenheit-style convert transform `y = 5*(x - 32) mod 256`.
- Recovers x from y as `x = INV_SCALE*y + OFFSET mod 2^WIDTH`. INV_SCALE=205 is the modular inverse of 5 mod 256.
- Uses an iterative shift-add multiplier with valid/ready handshakes on both sides.
- Sits downstream of the combinational convert stage in the regression harness, so round-trip checks can be made cycle-accurate.

---
 rtl/convert_inverse_seq_if.sv | 33 +++
 rtl/convert_inverse_seq.sv | 100 ++++++++++
 tb/tb_convert_inverse_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/convert_inverse_seq_if.sv
// Handshake bundle for the sequential inverse-convert decoder.
// master drives the input side and consumes results; slave is the decoder.
interface convert_inverse_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/convert_inverse_seq.sv
// Sequential decoder for y = 5*(x - 32) mod 2^WIDTH.
// Recovers x = INV_SCALE*y + OFFSET with a one-bit-per-cycle shift-add multiply.
module convert_inverse_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned INV_SCALE = 205,
    parameter int unsigned OFFSET    = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    convert_inverse_seq_if.slave bus
);
    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] INV_BITS = WIDTH'(INV_SCALE);
    localparam logic [WIDTH-1:0] OFF_BITS = WIDTH'(OFFSET);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and shift-add step; one multiplier bit is consumed per CALC cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        partial = INV_BITS[count_q] ? (mcand_q << count_q) : '0;
        acc_sum = acc_q + partial;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mcand_d = bus.in_data;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d   = acc_sum;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    // Final partial product folds straight into the result.
                    out_data_d  = acc_sum + OFF_BITS;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs follow the state register directly.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.busy      = (state_q != StIdle);
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
    end
endmodule

// File: tb/tb_convert_inverse_seq.sv
// Bench for convert_inverse_seq: directed transactions against a latency-level
// model plus literal expectations, and a full forward/inverse round-trip sweep.
module tb_convert_inverse_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    convert_inverse_seq_if #(.WIDTH(8)) bus ();

    convert_inverse_seq #(
        .WIDTH    (8),
        .INV_SCALE(205),
        .OFFSET   (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 computing, 2 result presented. Result appears 8 edges after accept.
    int       m_phase;
    int       m_left;
    int       m_y;
    int       m_x;
    int       m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_y     <= 0;
            m_x     <= 0;
            m_out   <= 0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_y     <= int'(bus.in_data);
                    m_x     <= (205 * int'(bus.in_data) + 32) % 256;
                    m_left  <= 8;
                    m_phase <= 1;
                end
                1: begin
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_out   <= m_x;
                    end
                    m_left <= m_left - 1;
                end
                2: if (bus.out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_in_ready", int'(bus.in_ready), int'(m_phase == 0));
            check("m_busy", int'(bus.busy), int'(m_phase != 0));
            check("m_out_valid", int'(bus.out_valid), int'(m_phase == 2));
            if (m_phase == 2) begin
                check("m_out_data", int'(bus.out_data), m_out);
                check("m_invariant", (5 * (int'(bus.out_data) - 32)) & 255, m_y);
            end
        end
    end

    // One transaction; wiggle>0 keeps in_valid high with random data for that many cycles.
    task automatic run_txn(input logic [7:0] y, input logic [7:0] exp, input int hold,
                           input int wiggle, output logic [7:0] got);
        int k;
        bit seen;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = y;
        bus.out_ready = (hold == 0);
        k    = 0;
        seen = 1'b0;
        got  = 8'h00;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) seen = 1'b1;
            if (k < wiggle) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("latency", k, 9);
        if (seen) begin
            got = bus.out_data;
            check("out_data", int'(got), int'(exp));
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_out_valid", int'(bus.out_valid), 1);
                check("bp_out_data", int'(bus.out_data), int'(exp));
                check("bp_in_ready", int'(bus.in_ready), 0);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("post_out_valid", int'(bus.out_valid), 0);
        check("post_in_ready", int'(bus.in_ready), 1);
    endtask

    logic [7:0] got;
    logic [255:0] seen_x;
    int distinct;

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic transactions with hand-computed results.
        run_txn(8'h00, 8'd32, 0, 0, got);
        run_txn(8'h05, 8'd33, 0, 0, got);
        run_txn(8'h01, 8'd237, 0, 0, got);
        run_txn(8'h80, 8'd160, 0, 0, got);
        run_txn(8'hFB, 8'd31, 0, 0, got);

        // Back-pressure for 20 cycles.
        run_txn(8'h05, 8'd33, 20, 0, got);

        // in_valid held with changing data during the computation.
        run_txn(8'h05, 8'd33, 0, 7, got);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_out_data", int'(bus.out_data), 0);
        check("arst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_in_ready", int'(bus.in_ready), 1);
        run_txn(8'h01, 8'd237, 0, 0, got);

        // Round-trip sweep: encode every x with the forward transform, decode it back.
        seen_x = '0;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] y;
            y = 8'((5 * (v - 32)) & 255);
            run_txn(y, 8'(v), 0, 0, got);
            seen_x[got] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 256; i++) distinct += int'(seen_x[i]);
        check("distinct_outputs", distinct, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog actual timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
